clk_phase_gen: RTL and testbench

- Programmable clock generator: the transmit-side counterpart of the clock-buffer measurement bench.
- Derives a generated clock gclk from master clock mclk with configurable period, high time and start phase, all counted in mclk cycles.
- Config updates are double-buffered and take effect only at period boundaries, so gclk never glitches.
- Feeds downstream blocks and the frequency/phase checker benches.

---
 rtl/clk_phase_gen.sv | 151 +++++++++++++++
 tb/tb_clk_phase_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_phase_gen.sv
// clk_phase_gen: programmable generated clock (period/high/phase) from mclk.
// New configs are staged and only go live at a period boundary.
module clk_phase_gen #(
    parameter int W          = 8,
    parameter int DEF_PERIOD = 2,
    parameter int DEF_HIGH   = 1,
    parameter int DEF_PHASE  = 0
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    input  logic [W-1:0] cfg_phase,
    output logic         cfg_err,
    output logic         gclk,
    output logic         gclk_rise,
    output logic         busy,
    output logic [15:0]  per_cnt
);
    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] act_per, act_high, act_phase;
    logic [W-1:0] act_per_n, act_high_n, act_phase_n;
    logic [W-1:0] pend_per, pend_high, pend_phase;
    logic [W-1:0] pend_per_n, pend_high_n, pend_phase_n;
    logic         pend_full, pend_full_n;
    logic         gclk_n, rise_n, err_n;
    logic [15:0]  per_cnt_n;
    logic         accept, cfg_ok, at_end;

    assign cfg_ready = ~pend_full;
    assign busy      = (state != IDLE);
    assign accept    = cfg_valid & cfg_ready;
    assign cfg_ok    = (cfg_period >= W'(2)) && (cfg_high != '0) &&
                       (cfg_high < cfg_period) && (cfg_phase < cfg_period);
    assign at_end    = (state == RUN) && (cnt == act_per - W'(1));

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        gclk_n       = 1'b0;
        rise_n       = 1'b0;
        err_n        = 1'b0;
        per_cnt_n    = per_cnt;
        act_per_n    = act_per;
        act_high_n   = act_high;
        act_phase_n  = act_phase;
        pend_per_n   = pend_per;
        pend_high_n  = pend_high;
        pend_phase_n = pend_phase;
        pend_full_n  = pend_full;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n   = ALIGN;
                    cnt_n     = act_phase;
                    per_cnt_n = '0;
                end
            end
            ALIGN: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = RUN;
                    gclk_n  = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt - W'(1);
                end
            end
            RUN: begin
                if (at_end) begin
                    cnt_n = '0;
                    if (per_cnt != 16'hFFFF)
                        per_cnt_n = per_cnt + 16'd1;
                    if (en) begin
                        gclk_n = 1'b1;
                        rise_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n  = cnt + W'(1);
                    gclk_n = (cnt_n < act_high);
                end
            end
            default: state_n = IDLE;
        endcase

        // staged config must not be stranded when leaving for IDLE
        if (pend_full && (at_end || (state == ALIGN && !en))) begin
            act_per_n   = pend_per;
            act_high_n  = pend_high;
            act_phase_n = pend_phase;
            pend_full_n = 1'b0;
        end

        if (accept) begin
            if (!cfg_ok) begin
                err_n = 1'b1;
            end else if (state == IDLE) begin
                act_per_n   = cfg_period;
                act_high_n  = cfg_high;
                act_phase_n = cfg_phase;
            end else begin
                pend_per_n   = cfg_period;
                pend_high_n  = cfg_high;
                pend_phase_n = cfg_phase;
                pend_full_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            gclk       <= 1'b0;
            gclk_rise  <= 1'b0;
            cfg_err    <= 1'b0;
            per_cnt    <= '0;
            act_per    <= W'(DEF_PERIOD);
            act_high   <= W'(DEF_HIGH);
            act_phase  <= W'(DEF_PHASE);
            pend_per   <= '0;
            pend_high  <= '0;
            pend_phase <= '0;
            pend_full  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gclk       <= gclk_n;
            gclk_rise  <= rise_n;
            cfg_err    <= err_n;
            per_cnt    <= per_cnt_n;
            act_per    <= act_per_n;
            act_high   <= act_high_n;
            act_phase  <= act_phase_n;
            pend_per   <= pend_per_n;
            pend_high  <= pend_high_n;
            pend_phase <= pend_phase_n;
            pend_full  <= pend_full_n;
        end
    end
endmodule

// File: tb/tb_clk_phase_gen.sv
// tb_clk_phase_gen: directed + random episodes checked against a
// period-list model of the expected gclk waveform.
module tb_clk_phase_gen;
    localparam int W = 8;

    logic         mclk = 1'b0;
    logic         rst_n, en, cfg_valid;
    logic         cfg_ready, cfg_err, gclk, gclk_rise, busy;
    logic [W-1:0] cfg_period, cfg_high, cfg_phase;
    logic [15:0]  per_cnt;

    int checks = 0;
    int failures = 0;
    int an = 2, ah = 1, ap = 0;

    always #5 mclk = ~mclk;

    clk_phase_gen #(
        .W(W), .DEF_PERIOD(2), .DEF_HIGH(1), .DEF_PHASE(0)
    ) dut (
        .mclk(mclk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_high(cfg_high),
        .cfg_phase(cfg_phase), .cfg_err(cfg_err),
        .gclk(gclk), .gclk_rise(gclk_rise),
        .busy(busy), .per_cnt(per_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_valid(input int n, input int h, input int p);
        return (n >= 2) && (h >= 1) && (h <= n - 1) && (p <= n - 1);
    endfunction

    task automatic set_cfg(input int n, input int h, input int p);
        logic [31:0] vn, vh, vp;
        vn = n; vh = h; vp = p;
        cfg_period = vn[W-1:0];
        cfg_high   = vh[W-1:0];
        cfg_phase  = vp[W-1:0];
    endtask

    task automatic offer_idle(input int n, input int h, input int p);
        bit ok;
        ok = is_valid(n, h, p);
        set_cfg(n, h, p);
        cfg_valid = 1'b1;
        en = 1'b0;
        @(posedge mclk); #1;
        cfg_valid = 1'b0;
        chk("idle_cfg_err", 32'(cfg_err), 32'(!ok));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gclk", 32'(gclk), 32'd0);
        if (ok) begin
            an = n; ah = h; ap = p;
        end
    endtask

    // Sample s is taken just after edge s; en is first seen at edge 0.
    task automatic run_ep(input bit chg, input int n2, input int h2,
                          input int p2, input int a, input int d);
        int st[$];
        int pn[$];
        int ph[$];
        int e, b, nxt, g, r, pc;
        bit use_chg, rdy;
        use_chg = chg && (d > ap + 1) && (a >= 1) && (a < d);
        if (d <= ap + 1) begin
            e = d;
        end else begin
            nxt = ap + 1;
            while (nxt < d) begin
                st.push_back(nxt);
                if (st.size() > 1 && use_chg && a < nxt) begin
                    pn.push_back(n2); ph.push_back(h2);
                end else begin
                    pn.push_back(an); ph.push_back(ah);
                end
                nxt += pn[pn.size() - 1];
            end
            e = nxt;
        end
        b = e;
        for (int j = st.size() - 1; j >= 1; j--)
            if (st[j] > a) b = st[j];

        for (int s = 0; s <= e + 2; s++) begin
            en = (s < d);
            cfg_valid = use_chg && (s == a);
            set_cfg(n2, h2, p2);
            @(posedge mclk); #1;
            cfg_valid = 1'b0;
            g = 0; r = 0; pc = 0;
            for (int j = 0; j < st.size(); j++) begin
                if (s >= st[j] && s < st[j] + pn[j] && s < e) begin
                    g = ((s - st[j]) < ph[j]) ? 1 : 0;
                    r = (s == st[j]) ? 1 : 0;
                end
                if (j >= 1 && st[j] <= s) pc++;
            end
            if (st.size() > 0 && s >= e) pc++;
            rdy = !(use_chg && s >= a && s < b);
            chk("gclk", 32'(gclk), g);
            chk("gclk_rise", 32'(gclk_rise), r);
            chk("busy", 32'(busy), 32'(s < e));
            chk("per_cnt", 32'(per_cnt), pc);
            chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
            chk("cfg_err", 32'(cfg_err), 32'd0);
        end
        en = 1'b0;
        if (use_chg) begin
            an = n2; ah = h2; ap = p2;
        end
    endtask

    initial begin
        int n, h, p, n2, h2, p2, a, d, k;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0);
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_gclk", 32'(gclk), 32'd0);
        chk("rst_rise", 32'(gclk_rise), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_per_cnt", 32'(per_cnt), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst_n = 1'b1;

        run_ep(1'b0, 0, 0, 0, 0, 12);
        offer_idle(10, 3, 4);
        run_ep(1'b0, 0, 0, 0, 0, 36);
        offer_idle(10, 3, 4);
        run_ep(1'b1, 6, 2, 0, 8, 45);

        offer_idle(1, 1, 0);
        offer_idle(8, 8, 0);
        offer_idle(8, 2, 9);
        run_ep(1'b0, 0, 0, 0, 0, 20);

        offer_idle(10, 3, 4);
        run_ep(1'b0, 0, 0, 0, 0, 3);
        run_ep(1'b0, 0, 0, 0, 0, 7);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 3);
                n = $urandom_range(2, 11); h = 1; p = 0;
                unique case (k)
                    0: n = $urandom_range(0, 1);
                    1: h = 0;
                    2: h = n + $urandom_range(0, 2);
                    default: p = n + $urandom_range(0, 2);
                endcase
                offer_idle(n, h, p);
            end
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(2, 12);
                h = $urandom_range(1, n - 1);
                p = $urandom_range(0, n - 1);
                offer_idle(n, h, p);
            end
            n2 = $urandom_range(2, 12);
            h2 = $urandom_range(1, n2 - 1);
            p2 = $urandom_range(0, n2 - 1);
            d = $urandom_range(1, 60);
            a = $urandom_range(1, (d > 1) ? d - 1 : 1);
            run_ep(1'($urandom_range(0, 1)), n2, h2, p2, a, d);
        end

        offer_idle(10, 3, 0);
        en = 1'b1;
        @(posedge mclk); #1;
        chk("mid_align_gclk", 32'(gclk), 32'd0);
        @(posedge mclk); #1;
        chk("mid_run_gclk0", 32'(gclk), 32'd1);
        @(posedge mclk); #1;
        chk("mid_run_gclk1", 32'(gclk), 32'd1);
        rst_n = 1'b0; en = 1'b0;
        @(posedge mclk); #1;
        chk("mid_rst_gclk", 32'(gclk), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_per_cnt", 32'(per_cnt), 32'd0);
        chk("mid_rst_rise", 32'(gclk_rise), 32'd0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;
        an = 2; ah = 1; ap = 0;
        run_ep(1'b0, 0, 0, 0, 0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
